// File: rtl/game_pkg.sv
// Shared encodings, LCD character codes and default timing for the runner-game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_MENU  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] CH_DINO_GND = 8'h00;
    localparam logic [7:0] CH_DINO_AIR = 8'h03;
    localparam logic [7:0] CH_OBSTACLE = 8'h04;
    localparam logic [7:0] CH_SPACE    = 8'h20;

    localparam int unsigned LEVEL_W           = 4;
    localparam int unsigned DEF_SCORE_W       = 32;
    localparam int unsigned DEF_TICK_INIT     = 250000;
    localparam int unsigned DEF_TICK_MIN      = 62500;
    localparam int unsigned DEF_TICK_STEP     = 25000;
    localparam int unsigned DEF_LEVEL_PTS     = 10;
    localparam int unsigned DEF_MAX_LEVEL     = 15;
    localparam int unsigned DEF_HOLDOFF_TICKS = 4;

    // Scroll period for a level, saturating at p_min without wrapping below zero.
    function automatic int unsigned target_period(input int unsigned lvl,
                                                  input int unsigned p_init,
                                                  input int unsigned p_min,
                                                  input int unsigned p_step);
        int unsigned dec;
        dec = lvl * p_step;
        if ((dec >= p_init) || ((p_init - dec) < p_min))
            return p_min;
        return p_init - dec;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Key/obstacle inputs and game-flow outputs of the flow controller, bundled as one port.
interface game_flow_ctrl_if #(
    parameter int unsigned SCORE_W  = 32,
    parameter int unsigned PERIOD_W = 18
);
    logic                font_done;
    logic                key_digit;
    logic                key_hash;
    logic                collide;
    logic [SCORE_W-1:0]  score;

    logic [2:0]          state;
    logic                start_game;
    logic                shift_enable;
    logic                jump_trigger;
    logic                force_game_over;
    logic [3:0]          level;
    logic [PERIOD_W-1:0] tick_period;
    logic [SCORE_W-1:0]  high_score;
    logic                new_record;

    // The controller side.
    modport slave (
        input  font_done, key_digit, key_hash, collide, score,
        output state, start_game, shift_enable, jump_trigger, force_game_over,
        output level, tick_period, high_score, new_record
    );

    // The environment side: key triggers, obstacle manager and display composers.
    modport master (
        output font_done, key_digit, key_hash, collide, score,
        input  state, start_game, shift_enable, jump_trigger, force_game_over,
        input  level, tick_period, high_score, new_record
    );
endinterface

// File: rtl/game_tick_gen.sv
// Programmable scroll-period counter; the period register only reloads at a wrap or a clear,
// so the period in force never changes mid-tick.
module game_tick_gen #(
    parameter int unsigned PERIOD_W   = 18,
    parameter int unsigned PERIOD_RST = 250000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] next_period,
    output logic                wrap_c,
    output logic [PERIOD_W-1:0] tick_period
);

    logic [PERIOD_W-1:0] cnt;

    assign wrap_c = enable && !clear && (cnt == (tick_period - PERIOD_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            tick_period <= PERIOD_W'(PERIOD_RST);
        end else if (clear) begin
            cnt         <= '0;
            tick_period <= next_period;
        end else if (wrap_c) begin
            cnt         <= '0;
            tick_period <= next_period;
        end else if (enable) begin
            cnt         <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow for the keypad/LCD runner: LOAD/MENU/PLAY/PAUSE/OVER sequencing,
// difficulty levels that shorten the scroll tick, restart hold-off and high-score tracking.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SCORE_W       = DEF_SCORE_W,
    parameter int unsigned TICK_INIT     = DEF_TICK_INIT,
    parameter int unsigned TICK_MIN      = DEF_TICK_MIN,
    parameter int unsigned TICK_STEP     = DEF_TICK_STEP,
    parameter int unsigned LEVEL_PTS     = DEF_LEVEL_PTS,
    parameter int unsigned MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int unsigned HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
    parameter int unsigned PERIOD_W      = $clog2(TICK_INIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  bus
);

    localparam int unsigned HO_W = (HOLDOFF_TICKS < 2) ? 1 : $clog2(HOLDOFF_TICKS + 1);

    state_t              st;
    state_t              next_st;
    logic                start_c;
    logic                quit_c;
    logic                jump_c;
    logic                enter_over_c;
    logic                holdoff_done_c;
    logic                wrap_c;

    logic                start_q;
    logic                shift_q;
    logic                jump_q;
    logic                quit_q;
    logic                record_q;
    logic [SCORE_W-1:0]  high_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [SCORE_W-1:0]  thr_q;
    logic [PERIOD_W-1:0] hold_cnt;
    logic [HO_W-1:0]     ho_ticks;
    logic [PERIOD_W-1:0] load_period_c;
    logic [PERIOD_W-1:0] period_w;

    assign holdoff_done_c = (ho_ticks == HO_W'(HOLDOFF_TICKS));
    assign enter_over_c   = (next_st == ST_OVER) && (st != ST_OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_LOAD;
        else     st <= next_st;
    end

    // Next state and single-cycle event decode; collide beats pause beats jump in PLAY.
    always_comb begin
        next_st = st;
        start_c = 1'b0;
        quit_c  = 1'b0;
        jump_c  = 1'b0;
        case (st)
            ST_LOAD: begin
                if (bus.font_done) next_st = ST_MENU;
            end
            ST_MENU: begin
                if (bus.key_digit) begin
                    next_st = ST_PLAY;
                    start_c = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.collide)        next_st = ST_OVER;
                else if (bus.key_hash)  next_st = ST_PAUSE;
                else if (bus.key_digit) jump_c  = 1'b1;
            end
            ST_PAUSE: begin
                if (bus.key_hash) begin
                    next_st = ST_PLAY;
                end else if (bus.key_digit) begin
                    next_st = ST_OVER;
                    quit_c  = 1'b1;
                end
            end
            ST_OVER: begin
                if (holdoff_done_c && (bus.key_digit || bus.key_hash)) begin
                    next_st = ST_PLAY;
                    start_c = 1'b1;
                end
            end
            default: next_st = ST_LOAD;
        endcase
    end

    // A new round always restarts at level 0, so its first tick uses the base period.
    assign load_period_c = start_c ? PERIOD_W'(TICK_INIT)
                                   : PERIOD_W'(target_period(32'(level_q), TICK_INIT,
                                                             TICK_MIN, TICK_STEP));

    game_tick_gen #(
        .PERIOD_W   (PERIOD_W),
        .PERIOD_RST (TICK_INIT)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .enable      (st == ST_PLAY),
        .clear       (start_c),
        .next_period (load_period_c),
        .wrap_c      (wrap_c),
        .tick_period (period_w)
    );

    // Pulses and score bookkeeping; a wrap on the cycle that leaves PLAY is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= 1'b0;
            shift_q  <= 1'b0;
            jump_q   <= 1'b0;
            quit_q   <= 1'b0;
            record_q <= 1'b0;
            high_q   <= '0;
        end else begin
            start_q <= start_c;
            shift_q <= wrap_c && (next_st == ST_PLAY);
            jump_q  <= jump_c;
            quit_q  <= quit_c;
            if (enter_over_c) begin
                record_q <= (bus.score > high_q);
                if (bus.score > high_q) high_q <= bus.score;
            end else if (start_c) begin
                record_q <= 1'b0;
            end
        end
    end

    // Difficulty: at most one level step per cycle so large score jumps catch up gradually.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            thr_q   <= '0;
        end else if (start_c) begin
            level_q <= '0;
            thr_q   <= SCORE_W'(LEVEL_PTS);
        end else if ((st == ST_PLAY) && (bus.score >= thr_q) &&
                     (level_q < LEVEL_W'(MAX_LEVEL))) begin
            level_q <= level_q + LEVEL_W'(1);
            thr_q   <= thr_q + SCORE_W'(LEVEL_PTS);
        end
    end

    // Restart hold-off, counted in base ticks from the first OVER cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            ho_ticks <= '0;
        end else if (enter_over_c) begin
            hold_cnt <= '0;
            ho_ticks <= '0;
        end else if ((st == ST_OVER) && !holdoff_done_c) begin
            if (hold_cnt == PERIOD_W'(TICK_INIT - 1)) begin
                hold_cnt <= '0;
                ho_ticks <= ho_ticks + HO_W'(1);
            end else begin
                hold_cnt <= hold_cnt + PERIOD_W'(1);
            end
        end
    end

    assign bus.state           = st;
    assign bus.start_game      = start_q;
    assign bus.shift_enable    = shift_q;
    assign bus.jump_trigger    = jump_q;
    assign bus.force_game_over = quit_q;
    assign bus.level           = level_q;
    assign bus.tick_period     = period_w;
    assign bus.high_score      = high_q;
    assign bus.new_record      = record_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scenario bench for game_flow_ctrl using small timing parameters and an expectation queue.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int unsigned SW    = 32;
    localparam int unsigned TI    = 20;
    localparam int unsigned TMIN  = 8;
    localparam int unsigned TSTEP = 4;
    localparam int unsigned LP    = 3;
    localparam int unsigned ML    = 15;
    localparam int unsigned HO    = 2;
    localparam int unsigned PW    = $clog2(TI + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;

    game_flow_ctrl_if #(.SCORE_W(SW), .PERIOD_W(PW)) bus ();

    game_flow_ctrl #(
        .SCORE_W(SW), .TICK_INIT(TI), .TICK_MIN(TMIN), .TICK_STEP(TSTEP),
        .LEVEL_PTS(LP), .MAX_LEVEL(ML), .HOLDOFF_TICKS(HO), .PERIOD_W(PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_period(input int lvl);
        int p;
        p = int'(TI) - lvl * int'(TSTEP);
        return (p < int'(TMIN)) ? int'(TMIN) : p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.font_done = 1'b0; bus.key_digit = 1'b0; bus.key_hash = 1'b0;
        bus.collide = 1'b0;   bus.score = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        sb.push_back(64'(ST_LOAD)); sb.push_back(64'(TI)); sb.push_back(64'd0);
        sb.push_back(64'd0); sb.push_back(64'd0);
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.tick_period) !== exp_v) begin errors++; $display("FAIL reset_period: got %0d expected %0d", bus.tick_period, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.level) !== exp_v) begin errors++; $display("FAIL reset_level: got %0d expected %0d", bus.level, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.high_score) !== exp_v) begin errors++; $display("FAIL reset_high: got %0d expected %0d", bus.high_score, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'({bus.start_game, bus.shift_enable, bus.jump_trigger, bus.force_game_over, bus.new_record}) !== exp_v) begin
            errors++; $display("FAIL reset_flags: got %b expected %0d",
                {bus.start_game, bus.shift_enable, bus.jump_trigger, bus.force_game_over, bus.new_record}, exp_v);
        end
    endtask

    task automatic test_start();
        int n;
        bus.font_done = 1'b1;
        sb.push_back(64'(ST_MENU));
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL load_to_menu: got %0d expected %0d", bus.state, exp_v); end
        bus.key_hash = 1'b1;
        sb.push_back(64'(ST_MENU));
        step();
        bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL menu_hash_ignored: got %0d expected %0d", bus.state, exp_v); end
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_PLAY)); sb.push_back(64'd1);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL menu_to_play: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL start_pulse: got %0d expected %0d", bus.start_game, exp_v); end
        sb.push_back(64'd0);
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL start_one_cycle: got %0d expected %0d", bus.start_game, exp_v); end
        sb.push_back(64'(TI));
        n = 1;
        while (bus.shift_enable !== 1'b1 && n < 100) begin step(); n++; end
        exp_v = sb.pop_front(); checks++;
        if (64'(n) !== exp_v) begin errors++; $display("FAIL first_tick_delay: got %0d expected %0d", n, exp_v); end
    endtask

    task automatic test_levels();
        int n;
        int prev;
        prev = int'(TI);
        for (int i = 1; i <= 4; i++) begin
            bus.score = SW'(int'(LP) * i);
            sb.push_back(64'(i)); sb.push_back(64'(prev));
            sb.push_back(64'(prev)); sb.push_back(64'(model_period(i)));
            step();
            exp_v = sb.pop_front(); checks++;
            if (64'(bus.level) !== exp_v) begin errors++; $display("FAIL level_%0d: got %0d expected %0d", i, bus.level, exp_v); end
            exp_v = sb.pop_front(); checks++;
            if (64'(bus.tick_period) !== exp_v) begin errors++; $display("FAIL period_mid_tick_%0d: got %0d expected %0d", i, bus.tick_period, exp_v); end
            n = 1;
            while (bus.shift_enable !== 1'b1 && n < 100) begin step(); n++; end
            exp_v = sb.pop_front(); checks++;
            if (64'(n) !== exp_v) begin errors++; $display("FAIL tick_gap_%0d: got %0d expected %0d", i, n, exp_v); end
            exp_v = sb.pop_front(); checks++;
            if (64'(bus.tick_period) !== exp_v) begin errors++; $display("FAIL period_at_wrap_%0d: got %0d expected %0d", i, bus.tick_period, exp_v); end
            prev = model_period(i);
        end
    endtask

    task automatic test_jump();
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_PLAY)); sb.push_back(64'd1);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL jump_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.jump_trigger) !== exp_v) begin errors++; $display("FAIL jump_pulse: got %0d expected %0d", bus.jump_trigger, exp_v); end
        sb.push_back(64'd0);
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.jump_trigger) !== exp_v) begin errors++; $display("FAIL jump_one_cycle: got %0d expected %0d", bus.jump_trigger, exp_v); end
    endtask

    task automatic test_pause();
        int n;
        int se;
        int bad;
        n = 0;
        sb.push_back(64'd1);
        while (bus.shift_enable !== 1'b1 && n < 100) begin step(); n++; end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.shift_enable) !== exp_v) begin errors++; $display("FAIL pause_sync_tick: got %0d expected %0d", bus.shift_enable, exp_v); end
        repeat (3) step();
        bus.key_hash = 1'b1;
        sb.push_back(64'(ST_PAUSE));
        step();
        bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL enter_pause: got %0d expected %0d", bus.state, exp_v); end
        se = 0; bad = 0;
        sb.push_back(64'd0); sb.push_back(64'd0);
        repeat (100) begin
            step();
            if (bus.shift_enable === 1'b1) se++;
            if (bus.state !== 3'(ST_PAUSE)) bad++;
        end
        exp_v = sb.pop_front(); checks++;
        if (64'(se) !== exp_v) begin errors++; $display("FAIL pause_ticks: got %0d expected %0d", se, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bad) !== exp_v) begin errors++; $display("FAIL pause_held: got %0d expected %0d", bad, exp_v); end
        bus.key_hash = 1'b1;
        sb.push_back(64'(ST_PLAY)); sb.push_back(64'd0);
        step();
        bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL resume_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL resume_no_start: got %0d expected %0d", bus.start_game, exp_v); end
        // Four counts were spent before the pause; the rest of the period remains.
        sb.push_back(64'(model_period(4) - 4 + 1));
        n = 1;
        while (bus.shift_enable !== 1'b1 && n < 100) begin step(); n++; end
        exp_v = sb.pop_front(); checks++;
        if (64'(n) !== exp_v) begin errors++; $display("FAIL resume_tick_gap: got %0d expected %0d", n, exp_v); end
    endtask

    task automatic test_quit_record();
        bus.score = SW'(7);
        bus.key_hash = 1'b1;
        sb.push_back(64'(ST_PAUSE));
        step();
        bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL quit_pause: got %0d expected %0d", bus.state, exp_v); end
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_OVER)); sb.push_back(64'd1); sb.push_back(64'd7); sb.push_back(64'd1);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL quit_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.force_game_over) !== exp_v) begin errors++; $display("FAIL quit_pulse: got %0d expected %0d", bus.force_game_over, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.high_score) !== exp_v) begin errors++; $display("FAIL quit_high: got %0d expected %0d", bus.high_score, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.new_record) !== exp_v) begin errors++; $display("FAIL quit_record: got %0d expected %0d", bus.new_record, exp_v); end
        sb.push_back(64'd0);
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.force_game_over) !== exp_v) begin errors++; $display("FAIL quit_one_cycle: got %0d expected %0d", bus.force_game_over, exp_v); end
    endtask

    task automatic test_over_holdoff();
        repeat (44) step();
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_PLAY)); sb.push_back(64'd1); sb.push_back(64'd0);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL restart_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL restart_start: got %0d expected %0d", bus.start_game, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.new_record) !== exp_v) begin errors++; $display("FAIL restart_record_clr: got %0d expected %0d", bus.new_record, exp_v); end
        bus.score = SW'(5);
        bus.collide = 1'b1;
        sb.push_back(64'(ST_OVER)); sb.push_back(64'd7); sb.push_back(64'd0);
        step();
        bus.collide = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL collide_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.high_score) !== exp_v) begin errors++; $display("FAIL collide_high: got %0d expected %0d", bus.high_score, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.new_record) !== exp_v) begin errors++; $display("FAIL collide_record: got %0d expected %0d", bus.new_record, exp_v); end
        repeat (30) step();
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_OVER)); sb.push_back(64'd0);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL holdoff_ignore: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL holdoff_no_start: got %0d expected %0d", bus.start_game, exp_v); end
        repeat (10) step();
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_PLAY)); sb.push_back(64'd1);
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL holdoff_accept: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.start_game) !== exp_v) begin errors++; $display("FAIL holdoff_start: got %0d expected %0d", bus.start_game, exp_v); end
    endtask

    task automatic test_back_to_back();
        bus.key_digit = 1'b1; bus.key_hash = 1'b1;
        sb.push_back(64'(ST_PAUSE)); sb.push_back(64'd0);
        step();
        bus.key_digit = 1'b0; bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL both_keys_pause: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.jump_trigger) !== exp_v) begin errors++; $display("FAIL both_keys_no_jump: got %0d expected %0d", bus.jump_trigger, exp_v); end
        bus.key_hash = 1'b1;
        sb.push_back(64'(ST_PLAY));
        step();
        bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL b2b_resume: got %0d expected %0d", bus.state, exp_v); end
        bus.collide = 1'b1; bus.key_hash = 1'b1;
        sb.push_back(64'(ST_OVER)); sb.push_back(64'd7);
        step();
        bus.collide = 1'b0; bus.key_hash = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL collide_beats_hash: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.high_score) !== exp_v) begin errors++; $display("FAIL b2b_high: got %0d expected %0d", bus.high_score, exp_v); end
        repeat (45) step();
        bus.key_digit = 1'b1;
        sb.push_back(64'(ST_PLAY));
        step();
        bus.key_digit = 1'b0;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL pre_reset_play: got %0d expected %0d", bus.state, exp_v); end
        repeat (3) step();
        bus.font_done = 1'b0;
        rst = 1'b1;
        sb.push_back(64'(ST_LOAD)); sb.push_back(64'(TI)); sb.push_back(64'd0);
        sb.push_back(64'd0); sb.push_back(64'd0);
        #2;
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", bus.state, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.tick_period) !== exp_v) begin errors++; $display("FAIL midrst_period: got %0d expected %0d", bus.tick_period, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.level) !== exp_v) begin errors++; $display("FAIL midrst_level: got %0d expected %0d", bus.level, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.high_score) !== exp_v) begin errors++; $display("FAIL midrst_high: got %0d expected %0d", bus.high_score, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (64'({bus.start_game, bus.shift_enable, bus.jump_trigger, bus.force_game_over, bus.new_record}) !== exp_v) begin
            errors++; $display("FAIL midrst_flags: got %b expected %0d",
                {bus.start_game, bus.shift_enable, bus.jump_trigger, bus.force_game_over, bus.new_record}, exp_v);
        end
        step();
        rst = 1'b0;
        sb.push_back(64'(ST_LOAD));
        step();
        exp_v = sb.pop_front(); checks++;
        if (64'(bus.state) !== exp_v) begin errors++; $display("FAIL post_rst_load: got %0d expected %0d", bus.state, exp_v); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_levels();
        test_jump();
        test_pause();
        test_quit_record();
        test_over_holdoff();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
